// File: rtl/kamacore_fetch_queue_pkg.sv
// Shared datatypes for the KamaCore instruction prefetch queue.
package kamacore_fetch_queue_pkg;

    localparam int unsigned CPU_WIDTH = 32;

    typedef struct packed {
        logic [CPU_WIDTH-1:0] pc;
        logic [CPU_WIDTH-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

    function automatic logic [CPU_WIDTH-1:0] word_align(input logic [CPU_WIDTH-1:0] addr);
        return {addr[CPU_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/kamacore_sync_fifo.sv
// Synchronous FIFO with push/pop/clear, combinational head read and occupancy count.
module kamacore_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // Storage is unreset; the consumer gates the head with its valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/kamacore_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues credit-limited requests, flushes on redirect.
// Optional feature macro: KAMACORE_FETCH_PERF_EN adds flush/starve performance counters.
module kamacore_fetch_queue
    import kamacore_fetch_queue_pkg::*;
#(
    parameter int unsigned          DEPTH    = 4,
    parameter logic [CPU_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    output logic [CPU_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_req_ready,
    input  logic                 imem_rsp_valid,
    input  logic [CPU_WIDTH-1:0] imem_rsp_data,
    input  logic                 redirect_valid,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 out_valid,
    output logic [CPU_WIDTH-1:0] out_pc,
    output logic [CPU_WIDTH-1:0] out_instr,
    input  logic                 out_ready
`ifdef KAMACORE_FETCH_PERF_EN
    ,
    output logic [31:0]          perf_flush_cnt,
    output logic [31:0]          perf_starve_cnt
`endif
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    fetch_state_e         state_q, state_d;
    logic [CPU_WIDTH-1:0] fetch_pc_q;
    logic [CPU_WIDTH-1:0] rsp_pc_q;
    logic [CPU_WIDTH-1:0] redirect_pc_al;
    logic [CW-1:0]        outstanding_q, outstanding_d;
    logic [CW-1:0]        discard_q, discard_d;
    logic [CW-1:0]        count;
    logic                 credit_ok;
    logic                 req_fire;
    logic                 push;
    logic                 pop;
    fetch_entry_t         push_entry;
    fetch_entry_t         head_entry;

    assign redirect_pc_al = word_align(redirect_pc);
    assign imem_req_addr  = word_align(fetch_pc_q);
    assign credit_ok      = (SW'(count) + SW'(outstanding_q)) < SW'(DEPTH);
    assign out_valid      = (count != '0);
    assign push           = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
    assign pop            = out_valid && out_ready && !redirect_valid;
    assign push_entry     = '{pc: rsp_pc_q, instr: imem_rsp_data};
    assign out_pc         = out_valid ? head_entry.pc    : '0;
    assign out_instr      = out_valid ? head_entry.instr : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_BOOT;
        else      state_q <= state_d;
    end

    // Next state, request valid, and credit/discard bookkeeping; redirect overrides all.
    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        req_fire       = 1'b0;
        outstanding_d  = outstanding_q;
        discard_d      = discard_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   imem_req_valid = credit_ok;
            S_FLUSH: ;
            default: state_d = S_BOOT;
        endcase
        req_fire      = imem_req_valid && imem_req_ready;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (imem_rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end
        if ((state_q == S_FLUSH) && (discard_d == '0)) begin
            state_d = S_RUN;
        end
        if (redirect_valid) begin
            discard_d = outstanding_d;
            state_d   = (outstanding_d != '0) ? S_FLUSH : S_RUN;
        end
    end

    // Request PC and response PC tracker advance independently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= word_align(RESET_PC);
            rsp_pc_q      <= word_align(RESET_PC);
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc_al;
                rsp_pc_q   <= redirect_pc_al;
            end else begin
                if (req_fire) fetch_pc_q <= fetch_pc_q + CPU_WIDTH'(4);
                if (push)     rsp_pc_q   <= rsp_pc_q + CPU_WIDTH'(4);
            end
        end
    end

    kamacore_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (redirect_valid),
        .head_data (head_entry),
        .count     (count)
    );

`ifdef KAMACORE_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_flush_cnt  <= '0;
            perf_starve_cnt <= '0;
        end else begin
            if (redirect_valid && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if (out_ready && !out_valid && (perf_starve_cnt != '1)) begin
                perf_starve_cnt <= perf_starve_cnt + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built.
`endif

endmodule

// File: tb/tb_kamacore_fetch_queue.sv
// Directed bench for kamacore_fetch_queue with an in-order, fixed-latency memory model.
module tb_kamacore_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
`ifdef KAMACORE_FETCH_PERF_EN
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_starve_cnt;
`endif

    int total = 0;
    int bad   = 0;

    int          mem_lat = 1;
    int          cyc = 0;
    int          req_total = 0;
    int          rsp_total = 0;
    int          pop_total = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] req_log[$];
    logic [31:0] cap_pc[$];
    logic [31:0] cap_instr[$];

    kamacore_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
`ifdef KAMACORE_FETCH_PERF_EN
        ,
        .perf_flush_cnt (perf_flush_cnt),
        .perf_starve_cnt(perf_starve_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model plus pop monitor; memory is reset together with the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rsp_valid <= 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + mem_lat);
                req_log.push_back(imem_req_addr);
                req_total++;
            end
            if (imem_rsp_valid) rsp_total++;
            if (out_valid && out_ready && !redirect_valid) begin
                cap_pc.push_back(out_pc);
                cap_instr.push_back(out_instr);
                pop_total++;
            end
            cyc++;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= instr_of(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its S_BOOT cycle, just after reset release.
    task automatic do_reset();
        rst            = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        mem_lat        = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cap_pc.delete();
        cap_instr.delete();
    endtask

    task automatic wait_cap(input int n, input string name);
        for (int c = 0; c < 40 && cap_pc.size() < n; c++) tick(1);
        total++;
        if (cap_pc.size() < n) begin
            bad++;
            $display("FAIL %s_timeout: got %0d pops, want %0d", name, cap_pc.size(), n);
        end
    endtask

    task automatic check_cap(input int idx, input logic [31:0] pc, input string name);
        logic [31:0] gp, gi;
        gp = (cap_pc.size() > idx) ? cap_pc[idx] : 32'hxxxx_xxxx;
        gi = (cap_pc.size() > idx) ? cap_instr[idx] : 32'hxxxx_xxxx;
        total++;
        if (gp !== pc) begin
            bad++;
            $display("FAIL %s_pc[%0d]: got %h want %h", name, idx, gp, pc);
        end
        total++;
        if (gi !== instr_of(pc)) begin
            bad++;
            $display("FAIL %s_instr[%0d]: got %h want %h", name, idx, gi, instr_of(pc));
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL boot_req_valid: got %b want 0", imem_req_valid); end
        tick(1);
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL run_req_valid: got %b want 1", imem_req_valid); end
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL run_req_addr: got %h want 0", imem_req_addr); end
    endtask

    task automatic test_streaming();
        int bubbles = 0;
        bit seen = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick(1);
            if (out_valid) seen = 1;
            else if (seen) bubbles++;
        end
        total++; if (bubbles != 0) begin bad++; $display("FAIL stream_bubbles: got %0d want 0", bubbles); end
        for (int i = 0; i < 12; i++) check_cap(i, 32'(4 * i), "stream");
    endtask

    task automatic test_backpressure();
        int rb, lb;
        logic [31:0] got;
        do_reset();
        tick(1);
        rb = req_total;
        lb = req_log.size();
        tick(10);
        total++; if (req_total - rb != 4) begin bad++; $display("FAIL bp_req_count: got %0d want 4", req_total - rb); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL bp_head_pc: got %h want 0", out_pc); end
        out_ready = 1'b1;
        tick(8);
        for (int i = 0; i < 4; i++) check_cap(i, 32'(4 * i), "bp");
        got = (req_log.size() > lb + 4) ? req_log[lb + 4] : 32'hxxxx_xxxx;
        total++; if (got !== 32'h10) begin bad++; $display("FAIL bp_next_req: got %h want 00000010", got); end
    endtask

    task automatic test_redirect_flush();
        int rb;
        do_reset();
        imem_req_ready = 1'b0;
        mem_lat        = 3;
        out_ready      = 1'b1;
        rb = req_total;
        tick(1);
        imem_req_ready = 1'b1;
        tick(2);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        total++; if (req_total - rb != 2) begin bad++; $display("FAIL rd_outstanding: got %0d want 2", req_total - rb); end
        tick(1);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rd_flush_req0: got %b want 0", imem_req_valid); end
        tick(1);
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rd_flush_req1: got %b want 0", imem_req_valid); end
        tick(1);
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rd_resume_req: got %b want 1", imem_req_valid); end
        total++; if (imem_req_addr !== 32'h100) begin bad++; $display("FAIL rd_resume_addr: got %h want 00000100", imem_req_addr); end
        wait_cap(2, "rd");
        check_cap(0, 32'h100, "rd");
        check_cap(1, 32'h104, "rd");
    endtask

    task automatic test_misaligned();
        bit found = 0;
        do_reset();
        tick(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick(1);
        redirect_valid = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (imem_req_valid) found = 1;
            else tick(1);
        end
        total++; if (!found) begin bad++; $display("FAIL mis_req_timeout: got none want request"); end
        total++; if (imem_req_addr !== 32'h100) begin bad++; $display("FAIL mis_req_addr: got %h want 00000100", imem_req_addr); end
        out_ready = 1'b1;
        wait_cap(1, "mis");
        check_cap(0, 32'h100, "mis");
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b1;
        tick(8);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid: got %b want 1", out_valid); end
        #3 rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_out_valid: got %b want 0", out_valid); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL ar_req_valid: got %b want 0", imem_req_valid); end
        @(posedge clk);
        #1 rst = 1'b1;
        cap_pc.delete();
        cap_instr.delete();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL ar_boot_req: got %b want 0", imem_req_valid); end
        tick(1);
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL ar_run_req: got %b want 1", imem_req_valid); end
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL ar_run_addr: got %h want 0", imem_req_addr); end
        wait_cap(1, "ar");
        check_cap(0, 32'h0, "ar");
    endtask

    task automatic test_pointer_wrap();
        int rb, pb, occ;
        int max_occ = 0;
        do_reset();
        rb = rsp_total;
        pb = pop_total;
        for (int c = 0; c < 300 && cap_pc.size() < 12; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick(1);
            occ = (rsp_total - rb) - (pop_total - pb) + pend_addr.size() + int'(imem_rsp_valid);
            if (occ > max_occ) max_occ = occ;
        end
        total++; if (cap_pc.size() < 12) begin bad++; $display("FAIL wrap_timeout: got %0d pops want 12", cap_pc.size()); end
        total++; if (max_occ > 4) begin bad++; $display("FAIL wrap_credit: got %0d want <=4", max_occ); end
        for (int i = 0; i < 12; i++) check_cap(i, 32'(4 * i), "wrap");
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_flush();
        test_misaligned();
        test_async_reset();
        test_pointer_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
